// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Drives the four-digit seven-segment display of the DPWM front panel.
//   The frequency or current value is selected and converted to BCD by a
//   shift-add (double-dabble) engine. The result is committed to a display
//   buffer, which is then scanned one digit per refresh slot.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   -> digits above the most significant nonzero digit are
//                  blanked (units digit always shown)
//     undefined -> all four digits shown, leading zeros rendered as "0"
//
// Ports
//   clk_d        in   display clock, all logic on the rising edge
//   reset        in   synchronous, active-low reset
//   frecuencia   in   8-bit frequency value (zero-extended when selected)
//   corriente    in   10-bit current value
//   control      in   source select: 1 = frecuencia, 0 = corriente
//   busy         out  high from LOAD through COMMIT of a conversion
//   conv_done    out  one-cycle pulse, in the cycle after a result is committed
//   digito       out  one-hot digit enable, bit0 = units
//   codificacion out  active-low segments, bit7 = DP (1), bits6..0 = a..g
//   o_dbg_state  out  conversion FSM state (IDLE=0, LOAD=1, SHIFT=2, COMMIT=3)
//
// Handshake: there is no back-pressure. conv_done is a status pulse that is
// high for exactly one cycle per committed result, and busy is low in that
// cycle. An observer that needs the result samples conv_done on every cycle.
module display_scan_controller #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic [7:0] frecuencia,
  input  logic [9:0] corriente,
  input  logic       control,
  output logic       busy,
  output logic       conv_done,
  output logic [3:0] digito,
  output logic [7:0] codificacion,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(REFRESH_DIV - 1);

  state_t      r_state;
  logic        r_force;
  logic [9:0]  r_last_val;
  logic [9:0]  r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] r_buf;
  logic        r_disp_valid;
  logic        r_busy;
  logic        r_conv_done;
  logic [15:0] r_refresh;
  logic [1:0]  r_idx;
  logic [3:0]  r_digito;
  logic [7:0]  r_codif;

  logic [9:0]  w_sel;
  logic [15:0] w_bcd_adj;
  logic [15:0] w_buf_next;
  logic        w_valid_next;
  logic [1:0]  w_idx_next;
  logic [3:0]  w_nib;
  logic        w_lead_zero;
  logic [7:0]  w_seg_next;

  assign w_sel = control ? {2'b00, frecuencia} : corriente;

  // Double-dabble correction: nibbles >= 5 get +3 before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM
  always_ff @(posedge clk_d) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_force      <= 1'b1;
      r_last_val   <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_disp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_conv_done  <= 1'b0;
    end else begin
      r_conv_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if ((w_sel != r_last_val) || r_force) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_bin      <= w_sel;
          r_last_val <= w_sel;
          r_bcd      <= '0;
          r_force    <= 1'b0;
          r_cnt      <= '0;
          r_state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
          if (r_cnt == 4'd9) r_state <= ST_COMMIT;
          else               r_cnt   <= r_cnt + 4'd1;
        end
        ST_COMMIT: begin
          r_buf        <= r_bcd;
          r_disp_valid <= 1'b1;
          r_conv_done  <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The scan pair is computed from the buffer as it will be after this
  // edge, so a digit advancing on the COMMIT edge already shows the new value.
  assign w_buf_next   = (r_state == ST_COMMIT) ? r_bcd : r_buf;
  assign w_valid_next = (r_state == ST_COMMIT) | r_disp_valid;
  assign w_idx_next   = r_idx + 2'd1;

  always_comb begin
    case (w_idx_next)
      2'd0:    w_nib = w_buf_next[3:0];
      2'd1:    w_nib = w_buf_next[7:4];
      2'd2:    w_nib = w_buf_next[11:8];
      default: w_nib = w_buf_next[15:12];
    endcase
  end

  always_comb begin
    w_lead_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (w_idx_next)
      2'd3:    w_lead_zero = (w_buf_next[15:12] == 4'd0);
      2'd2:    w_lead_zero = (w_buf_next[15:8] == 8'd0);
      2'd1:    w_lead_zero = (w_buf_next[15:4] == 12'd0);
      default: w_lead_zero = 1'b0;
    endcase
`endif
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign w_seg_next = (!w_valid_next || w_lead_zero) ? 8'hFF : {1'b1, seg_decode(w_nib)};

  // Scan timing: digit pair only changes on a slot boundary, never mid-slot.
  always_ff @(posedge clk_d) begin
    if (!reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
      r_digito  <= 4'b0001;
      r_codif   <= 8'hFF;
    end else if (r_refresh == LP_LAST) begin
      r_refresh <= '0;
      r_idx     <= w_idx_next;
      r_digito  <= 4'b0001 << w_idx_next;
      r_codif   <= w_seg_next;
    end else begin
      r_refresh <= r_refresh + 16'd1;
    end
  end

  assign busy         = r_busy;
  assign conv_done    = r_conv_done;
  assign digito       = r_digito;
  assign codificacion = r_codif;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  logic       clk_d = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] frecuencia = 8'd0;
  logic [9:0] corriente = 10'd0;
  logic       control = 1'b0;
  logic       busy;
  logic       conv_done;
  logic [3:0] digito;
  logic [7:0] codificacion;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  // Expected four-digit codes per committed conversion: {thousands, hundreds, tens, units}
  logic [31:0] exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'h81;
`endif
  localparam logic [7:0] S0 = 8'b10000001;
  localparam logic [7:0] S1 = 8'b11001111;
  localparam logic [7:0] S2 = 8'b10010010;
  localparam logic [7:0] S3 = 8'b10000110;
  localparam logic [7:0] S5 = 8'b10100100;
  localparam logic [7:0] S7 = 8'b10001111;

  display_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .frecuencia   (frecuencia),
    .corriente    (corriente),
    .control      (control),
    .busy         (busy),
    .conv_done    (conv_done),
    .digito       (digito),
    .codificacion (codificacion),
    .o_dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk_d = ~clk_d;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk_d);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!conv_done && n < max);
  endtask

  // Scoreboard monitor: each conv_done pops one expected entry; every digit
  // slot that starts after the commit is compared until all four are seen
  // or another result is committed.
  initial begin : monitor
    logic [31:0] cur;
    logic [3:0]  prev_dig;
    logic [3:0]  seen;
    logic        active;
    int          idx;
    active = 1'b0;
    cur = '0;
    seen = '0;
    prev_dig = '0;
    forever begin
      @(negedge clk_d);
      if (!reset) begin
        active = 1'b0;
      end else if (conv_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_conv_done", 32'd1, 32'd0);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          seen = '0;
          prev_dig = digito;
        end
      end else if (active && (digito != prev_dig)) begin
        prev_dig = digito;
        case (digito)
          4'b0001: idx = 0;
          4'b0010: idx = 1;
          4'b0100: idx = 2;
          4'b1000: idx = 3;
          default: idx = -1;
        endcase
        if (idx < 0) begin
          check("digito_onehot", {28'd0, digito}, 32'd0);
        end else begin
          check($sformatf("seg_digit%0d", idx), {24'd0, codificacion}, {24'd0, cur[idx*8 +: 8]});
          seen[idx] = 1'b1;
          if (seen == 4'hF) active = 1'b0;
        end
      end
    end
  end

  // Driver
  initial begin : driver
    int n;
    logic saw_busy;
    logic saw_done;

    // Reset held for 3 cycles
    control = 1'b1;
    frecuencia = 8'd75;
    reset = 1'b0;
    repeat (3) step();
    check("rst_digito", {28'd0, digito}, 32'h1);
    check("rst_codif", {24'd0, codificacion}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_conv_done", {31'd0, conv_done}, 32'd0);

    // Release: forced first conversion of 75
    exp_q.push_back({LZ, LZ, S7, S5});
    reset = 1'b1;
    step();
    check("rel_busy_cycle1", {31'd0, busy}, 32'd1);
    for (int k = 2; k <= 13; k++) begin
      step();
      if (k == 6) begin
        check("blank_digito", {28'd0, digito}, 32'h2);
        check("blank_codif", {24'd0, codificacion}, 32'hFF);
      end
      if (k == 12) begin
        check("rel_done_early", {31'd0, conv_done}, 32'd0);
        check("rel_busy_last", {31'd0, busy}, 32'd1);
      end
      if (k == 13) begin
        check("rel_done", {31'd0, conv_done}, 32'd1);
        check("rel_busy_off", {31'd0, busy}, 32'd0);
      end
    end
    repeat (30) step();

    // Current full scale 1023
    exp_q.push_back({S1, S0, S2, S3});
    control = 1'b0;
    corriente = 10'd1023;
    wait_done(20, n);
    check("lat_1023", n, 13);
    repeat (30) step();

    // Mid-conversion change 100 -> 200 during the 4th SHIFT cycle
    exp_q.push_back({LZ, S1, S0, S0});
    exp_q.push_back({LZ, S2, S0, S0});
    control = 1'b1;
    frecuencia = 8'd100;
    repeat (5) step();
    check("mid_busy", {31'd0, busy}, 32'd1);
    frecuencia = 8'd200;
    repeat (8) step();
    check("mid_done1", {31'd0, conv_done}, 32'd1);
    step();
    check("mid_restart_busy", {31'd0, busy}, 32'd1);
    wait_done(20, n);
    check("mid_lat2", n, 12);
    repeat (30) step();

    // Source switch with equal values: no new conversion
    exp_q.push_back({LZ, LZ, S3, S0});
    frecuencia = 8'd30;
    corriente = 10'd30;
    wait_done(20, n);
    check("lat_30", n, 13);
    repeat (30) step();
    control = 1'b0;
    saw_busy = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      step();
      saw_busy |= busy;
      saw_done |= conv_done;
    end
    check("switch_no_busy", {31'd0, saw_busy}, 32'd0);
    check("switch_no_done", {31'd0, saw_done}, 32'd0);

    // Reset during the 5th SHIFT cycle of 512
    corriente = 10'd512;
    repeat (6) step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step();
    check("midrst_digito", {28'd0, digito}, 32'h1);
    check("midrst_codif", {24'd0, codificacion}, 32'hFF);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, conv_done}, 32'd0);
    repeat (2) step();
    exp_q.push_back({LZ, S5, S1, S2});
    reset = 1'b1;
    n = 0;
    saw_done = 1'b0;
    for (int k = 1; k <= 20 && !saw_done; k++) begin
      step();
      n = k;
      saw_done = conv_done;
      if (k == 6) check("rerst_blank", {24'd0, codificacion}, 32'hFF);
    end
    check("rerst_lat", n, 13);
    repeat (30) step();

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
